// File: rtl/ctrl_vector_sequencer.sv
// Control-word player/checker: drives preloaded vectors onto a datapath bus,
// samples the observed result SETTLE cycles later and counts masked mismatches.
module ctrl_vector_sequencer #(
    parameter int VEC_W  = 42,
    parameter int OBS_W  = 8,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             LoadEn,
    input  logic [AW-1:0]    LoadAddr,
    input  logic [VEC_W-1:0] LoadVec,
    input  logic [OBS_W-1:0] LoadExp,
    input  logic [OBS_W-1:0] LoadMask,
    input  logic [AW:0]      NumVec,
    input  logic             Start,
    input  logic             StepMode,
    input  logic             StepReq,
    input  logic             Abort,
    input  logic [OBS_W-1:0] ObsIn,
    output logic [VEC_W-1:0] CtrlWord,
    output logic             CtrlValid,
    output logic             Busy,
    output logic             Done,
    output logic [AW-1:0]    VecIdx,
    output logic [ERR_W-1:0] ErrCount,
    output logic             FirstErr,
    output logic [AW-1:0]    FirstIdx
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 1) ? SETTLE - 2 : 0);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [VEC_W-1:0] vec_mem  [DEPTH];
    logic [OBS_W-1:0] exp_mem  [DEPTH];
    logic [OBS_W-1:0] mask_mem [DEPTH];

    logic [OBS_W-1:0] exp_q;
    logic [OBS_W-1:0] mask_q;
    logic [AW:0]      num_q;
    logic [SW-1:0]    settle_cnt;
    logic [AW-1:0]    apply_idx;
    logic             start_go;
    logic             score;
    logic             mismatch;
    logic             last;

    assign start_go  = ((state_q == S_IDLE) || (state_q == S_DONE)) && Start;
    assign score     = (state_q == S_CHECK) && !Abort;
    assign mismatch  = |((ObsIn ^ exp_q) & mask_q);
    assign last      = ({1'b0, VecIdx} == (num_q - 1'b1));
    assign Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign CtrlValid = Busy;
    assign Done      = (state_q == S_DONE);

    // Store is not reset; writes land in any state.
    always_ff @(posedge Clock) begin
        if (LoadEn) begin
            vec_mem[LoadAddr]  <= LoadVec;
            exp_mem[LoadAddr]  <= LoadExp;
            mask_mem[LoadAddr] <= LoadMask;
        end
    end

    always_comb begin
        apply_idx = VecIdx;
        if (start_go) begin
            apply_idx = '0;
        end else if ((state_q == S_CHECK) || (state_q == S_PAUSE)) begin
            apply_idx = VecIdx + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks step requests and end-of-run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) state_d = (NumVec == '0) ? S_DONE : S_APPLY;
            end
            S_APPLY: begin
                if (Abort) state_d = S_DONE;
                else state_d = (SETTLE > 1) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (Abort) state_d = S_DONE;
                else if (settle_cnt == SETTLE_LAST) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (Abort) state_d = S_DONE;
                else if (last) state_d = S_DONE;
                else if (StepMode) state_d = S_PAUSE;
                else state_d = S_APPLY;
            end
            S_PAUSE: begin
                if (Abort) state_d = S_DONE;
                else if (StepReq || !StepMode) state_d = S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            CtrlWord   <= '0;
            VecIdx     <= '0;
            ErrCount   <= '0;
            FirstErr   <= 1'b0;
            FirstIdx   <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            num_q      <= '0;
            settle_cnt <= '0;
        end else begin
            if (start_go) begin
                num_q    <= (NumVec > DEPTH_N) ? DEPTH_N : NumVec;
                ErrCount <= '0;
                FirstErr <= 1'b0;
                FirstIdx <= '0;
            end
            if (state_d == S_APPLY) begin
                CtrlWord <= vec_mem[apply_idx];
                exp_q    <= exp_mem[apply_idx];
                mask_q   <= mask_mem[apply_idx];
            end else if (state_d == S_DONE) begin
                CtrlWord <= '0;
            end
            if (start_go || (state_d == S_APPLY)) begin
                VecIdx <= apply_idx;
            end
            settle_cnt <= (state_q == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (score && mismatch) begin
                if (ErrCount != '1) ErrCount <= ErrCount + 1'b1;
                if (!FirstErr) begin
                    FirstErr <= 1'b1;
                    FirstIdx <= VecIdx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_vector_sequencer.sv
// Bench for ctrl_vector_sequencer: per-cycle comparison against a run-level
// model plus directed scenarios with hand-computed results.
module tb_ctrl_vector_sequencer;

    localparam int VEC_W  = 42;
    localparam int OBS_W  = 8;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 1;
    localparam int AW     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_en = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    logic [VEC_W-1:0] load_vec = '0;
    logic [OBS_W-1:0] load_exp = '0;
    logic [OBS_W-1:0] load_mask = '0;
    logic [AW:0]      num_vec = '0;
    logic             start = 1'b0;
    logic             step_mode = 1'b0;
    logic             step_req = 1'b0;
    logic             abort = 1'b0;
    logic [OBS_W-1:0] obs;

    logic [VEC_W-1:0] ctrl_word, s_ctrl_word;
    logic             ctrl_valid, s_valid;
    logic             busy, s_busy;
    logic             done, s_done;
    logic [AW-1:0]    vec_idx, s_idx;
    logic [7:0]       err_count;
    logic [1:0]       s_err;
    logic             first_err, s_first;
    logic [AW-1:0]    first_idx, s_fidx;

    // The datapath echoes the low byte of the control word as its result.
    assign obs = ctrl_word[OBS_W-1:0];

    always #5 clk = ~clk;

    ctrl_vector_sequencer dut (
        .Clock(clk), .Reset(rst), .LoadEn(load_en), .LoadAddr(load_addr),
        .LoadVec(load_vec), .LoadExp(load_exp), .LoadMask(load_mask),
        .NumVec(num_vec), .Start(start), .StepMode(step_mode),
        .StepReq(step_req), .Abort(abort), .ObsIn(obs),
        .CtrlWord(ctrl_word), .CtrlValid(ctrl_valid), .Busy(busy),
        .Done(done), .VecIdx(vec_idx), .ErrCount(err_count),
        .FirstErr(first_err), .FirstIdx(first_idx)
    );

    ctrl_vector_sequencer #(.ERR_W(2)) dut_sat (
        .Clock(clk), .Reset(rst), .LoadEn(load_en), .LoadAddr(load_addr),
        .LoadVec(load_vec), .LoadExp(load_exp), .LoadMask(load_mask),
        .NumVec(num_vec), .Start(start), .StepMode(step_mode),
        .StepReq(step_req), .Abort(abort), .ObsIn(obs),
        .CtrlWord(s_ctrl_word), .CtrlValid(s_valid), .Busy(s_busy),
        .Done(s_done), .VecIdx(s_idx), .ErrCount(s_err),
        .FirstErr(s_first), .FirstIdx(s_fidx)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: which vector is live, how long since it was applied.
    logic [VEC_W-1:0] m_vec  [DEPTH];
    logic [OBS_W-1:0] m_exp  [DEPTH];
    logic [OBS_W-1:0] m_mask [DEPTH];
    logic [VEC_W-1:0] m_cw = '0;
    logic [OBS_W-1:0] m_exp_l = '0;
    logic [OBS_W-1:0] m_mask_l = '0;
    bit m_run = 0, m_done = 0, m_paused = 0, m_first = 0;
    int m_idx = 0, m_age = 0, m_n = 0, m_err = 0, m_err2 = 0, m_fidx = 0;

    task automatic m_clear();
        m_run = 0; m_done = 0; m_paused = 0; m_first = 0;
        m_idx = 0; m_age = 0; m_n = 0; m_err = 0; m_err2 = 0; m_fidx = 0;
        m_cw = '0;
    endtask

    task automatic m_apply();
        m_cw = m_vec[m_idx];
        m_exp_l = m_exp[m_idx];
        m_mask_l = m_mask[m_idx];
        m_age = 0;
    endtask

    task automatic m_step();
        if (!m_run) begin
            if (start) begin
                m_err = 0; m_err2 = 0; m_first = 0; m_fidx = 0; m_idx = 0;
                m_paused = 0;
                m_n = (int'(num_vec) > DEPTH) ? DEPTH : int'(num_vec);
                if (m_n == 0) begin
                    m_done = 1;
                end else begin
                    m_done = 0; m_run = 1; m_apply();
                end
            end
        end else if (abort) begin
            m_run = 0; m_done = 1; m_paused = 0;
        end else if (m_paused) begin
            if (step_req || !step_mode) begin
                m_paused = 0; m_idx++; m_apply();
            end
        end else if (m_age < SETTLE) begin
            m_age++;
        end else begin
            if (((obs ^ m_exp_l) & m_mask_l) != '0) begin
                if (m_err < 255) m_err++;
                if (m_err2 < 3) m_err2++;
                if (!m_first) begin
                    m_first = 1; m_fidx = m_idx;
                end
            end
            if (m_idx == m_n - 1) begin
                m_run = 0; m_done = 1;
            end else if (step_mode) begin
                m_paused = 1;
            end else begin
                m_idx++; m_apply();
            end
        end
        if (load_en) begin
            m_vec[load_addr] = load_vec;
            m_exp[load_addr] = load_exp;
            m_mask[load_addr] = load_mask;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_clear();
            else m_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ctrl_word", 64'(ctrl_word), 64'(m_run ? m_cw : '0));
            chk("ctrl_valid", 64'(ctrl_valid), 64'(m_run));
            chk("busy", 64'(busy), 64'(m_run));
            chk("done", 64'(done), 64'(m_done));
            chk("vec_idx", 64'(vec_idx), 64'(m_idx));
            chk("err_count", 64'(err_count), 64'(m_err));
            chk("first_err", 64'(first_err), 64'(m_first));
            chk("first_idx", 64'(first_idx), 64'(m_fidx));
            chk("sat_err_count", 64'(s_err), 64'(m_err2));
            chk("sat_ctrl_word", 64'(s_ctrl_word), 64'(m_run ? m_cw : '0));
            chk("sat_done", 64'(s_done), 64'(m_done));
            chk("sat_vec_idx", 64'(s_idx), 64'(m_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [7:0] res, exp, mask);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_vec = {34'(a * 37 + 11), res};
        load_exp = exp;
        load_mask = mask;
        tick();
        load_en = 1'b0;
    endtask

    task automatic run(input int n, output int vcyc);
        num_vec = 5'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        vcyc = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (ctrl_valid) vcyc++;
            tick();
        end
        chk("run_reaches_done", 64'(done), 64'(1));
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_ctrl_word"}, 64'(ctrl_word), 64'(0));
        chk({tag, "_ctrl_valid"}, 64'(ctrl_valid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_vec_idx"}, 64'(vec_idx), 64'(0));
        chk({tag, "_err_count"}, 64'(err_count), 64'(0));
        chk({tag, "_first_err"}, 64'(first_err), 64'(0));
        chk({tag, "_first_idx"}, 64'(first_idx), 64'(0));
        chk({tag, "_sat_ctrl_word"}, 64'(s_ctrl_word), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        bit found;
        #2 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        zero_checks("reset");
        rst = 1'b0;
        tick();

        // Three matching vectors, free-run.
        load(0, 8'h05, 8'h05, 8'hFF);
        load(1, 8'h0A, 8'h0A, 8'hFF);
        load(2, 8'hFF, 8'hFF, 8'hFF);
        run(3, vc);
        chk("t1_valid_cycles", 64'(vc), 64'(6));
        chk("t1_err", 64'(err_count), 64'(0));
        chk("t1_first_err", 64'(first_err), 64'(0));

        // Mismatches on vectors 1 and 2.
        load(1, 8'h0B, 8'h0A, 8'hFF);
        load(2, 8'h00, 8'hFF, 8'hFF);
        run(3, vc);
        chk("t2_err", 64'(err_count), 64'(2));
        chk("t2_first_err", 64'(first_err), 64'(1));
        chk("t2_first_idx", 64'(first_idx), 64'(1));

        // Masked compare.
        load(0, 8'hF5, 8'h05, 8'h0F);
        run(1, vc);
        chk("t3_masked_ok", 64'(err_count), 64'(0));
        load(0, 8'h04, 8'h05, 8'h0F);
        run(1, vc);
        chk("t3_masked_err", 64'(err_count), 64'(1));

        // Single-step; stray Start and StepReq outside PAUSE are ignored.
        load(0, 8'h05, 8'h05, 8'hFF);
        load(1, 8'h0A, 8'h0A, 8'hFF);
        load(2, 8'hFF, 8'hFF, 8'hFF);
        step_mode = 1'b1;
        num_vec = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        num_vec = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("t4_pause_idx", 64'(vec_idx), 64'(0));
        chk("t4_pause_busy", 64'(busy), 64'(1));
        chk("t4_pause_done", 64'(done), 64'(0));
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("t4_step_idx", 64'(vec_idx), 64'(1));
        tick();
        tick();
        chk("t4_step_done", 64'(done), 64'(1));
        chk("t4_step_err", 64'(err_count), 64'(0));

        // Clearing StepMode while paused resumes free-run.
        num_vec = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("t5_paused_idx", 64'(vec_idx), 64'(0));
        step_mode = 1'b0;
        for (int c = 0; c < 50 && !done; c++) tick();
        chk("t5_done", 64'(done), 64'(1));
        chk("t5_idx", 64'(vec_idx), 64'(2));

        // NumVec beyond DEPTH clamps.
        for (int a = 3; a < DEPTH; a++) load(a, 8'(a * 17), 8'(a * 17), 8'hFF);
        run(20, vc);
        chk("t6_clamp_cycles", 64'(vc), 64'(32));
        chk("t6_clamp_idx", 64'(vec_idx), 64'(15));
        chk("t6_clamp_err", 64'(err_count), 64'(0));

        // Saturation of the narrow counter.
        for (int a = 0; a < 5; a++) load(a, ~8'(a * 17), 8'(a * 17), 8'hFF);
        run(5, vc);
        chk("t7_err_wide", 64'(err_count), 64'(5));
        chk("t7_err_sat", 64'(s_err), 64'(3));
        chk("t7_first_idx", 64'(first_idx), 64'(0));

        // Abort during the check of a mismatching vector.
        load(0, 8'h05, 8'h05, 8'hFF);
        load(1, 8'h0B, 8'h0A, 8'hFF);
        load(2, 8'hFF, 8'hFF, 8'hFF);
        num_vec = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_run && m_idx == 1 && m_age == SETTLE && !m_paused) found = 1'b1;
            else tick();
        end
        chk("t8_abort_window", 64'(found), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t8_abort_done", 64'(done), 64'(1));
        chk("t8_abort_valid", 64'(ctrl_valid), 64'(0));
        chk("t8_abort_word", 64'(ctrl_word), 64'(0));
        chk("t8_abort_err", 64'(err_count), 64'(0));

        // Async reset mid-run; store survives.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        zero_checks("midreset");
        #3 rst = 1'b0;
        tick();
        run(3, vc);
        chk("t9_retained_err", 64'(err_count), 64'(1));
        chk("t9_retained_fidx", 64'(first_idx), 64'(1));

        // NumVec=0 finishes without driving anything and clears counters.
        run(0, vc);
        for (int c = 0; c < 5; c++) begin
            if (ctrl_valid) vc++;
            tick();
        end
        chk("t10_zero_valid", 64'(vc), 64'(0));
        chk("t10_zero_done", 64'(done), 64'(1));
        chk("t10_zero_err", 64'(err_count), 64'(0));

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
